bs_rotate_left_iter: RTL and testbench
======================================

BS_ROTATE_LEFT_ITER -- requirements
Module: bs_rotate_left_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits (legal values 2..32).
REQ-002 The block SHALL have parameter KW, default 3, giving the rotate-amount width, equal to ceil(log2(WIDTH)).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 i_clk  input  1  clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_valid  input  1  request valid.
REQ-007 o_ready  output  1  block can accept a request this cycle.
REQ-008 i_A  input  WIDTH  operand to rotate.
REQ-009 i_k  input  KW  rotate-left amount; unsigned, 0..WIDTH-1.
REQ-010 o_valid  output  1  result valid.
REQ-011 i_ready  input  1  downstream accepts the result.
REQ-012 o_Y  output  WIDTH  rotated result.
REQ-013 o_busy  output  1  high in SHIFT or DONE.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE, all registered.
REQ-015 o_ready SHALL be high exactly when the state is IDLE; it is decoded combinationally from the state register.
REQ-016 Request accept:
- Occurs on a rising edge with i_valid=1 and o_ready=1.
- Latches i_A into a WIDTH-bit work register and i_k into a KW-bit down-counter.
- Next state is SHIFT if i_k!=0, otherwise DONE.
REQ-017 SHIFT behaviour:
- Each cycle: work = {work[WIDTH-2:0], work[WIDTH-1]}; counter decrements by 1.
- When the counter equals 1, the next state is DONE and o_Y is loaded with the final rotated value.
REQ-018 A zero rotate (i_k=0) SHALL load o_Y with i_A unchanged on entry to DONE.
REQ-019 Latency SHALL be k+1 clock edges from the accept edge to the first cycle with o_valid=1; SHIFT lasts exactly k cycles.
REQ-020 In DONE, o_valid SHALL be 1, and o_Y and o_valid SHALL hold stable until a rising edge with i_ready=1.
REQ-021 That i_ready edge SHALL return the state to IDLE and clear o_valid.
REQ-022 o_Y SHALL retain the last result after the handshake until the next DONE entry.
REQ-023 i_valid, i_A and i_k SHALL be ignored while the state is not IDLE; no request is queued.
REQ-024 i_ready SHALL be ignored outside DONE.
REQ-025 i_k values >= WIDTH are illegal when WIDTH is not a power of two; for those values the result is undefined but the FSM SHALL still return to IDLE.
REQ-026 Functional equivalence: the result SHALL equal rotate-right of i_A by (WIDTH-k) mod WIDTH.
REQ-027 Minimum spacing between two accepts SHALL be k+2 cycles (SHIFT + DONE + IDLE) when i_ready is held at 1.

Reset
REQ-028 On a rising edge with i_rst=1, the block SHALL reset as follows:
- state = IDLE
- o_valid = 0
- o_busy = 0
- o_Y = 0
- work register = 0
- counter = 0
REQ-029 Reset SHALL take priority over every other event, including an accept or a handshake on the same edge.
REQ-030 Reset during SHIFT or DONE SHALL abort the operation; no o_valid pulse follows.
REQ-031 o_ready SHALL be 1 in the cycle after the reset edge.

Verification (WIDTH=8 unless stated)
REQ-032 Basic rotate: i_A=8'hB4, i_k=3, i_ready=1 -> o_valid high 4 edges after accept, o_Y=8'hA5; then IDLE.
REQ-033 Zero rotate: i_A=8'h3C, i_k=0 -> o_valid 1 edge after accept, o_Y=8'h3C, no SHIFT cycles.
REQ-034 Maximum rotate with back-to-back: i_A=8'h01, i_k=7 -> o_Y=8'h80 after 8 edges; a second request offered during SHIFT is ignored and is accepted only once the block is back in IDLE.
REQ-035 Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid=1 and o_Y constant throughout; one i_ready=1 edge returns to IDLE.
REQ-036 Reset mid-operation: assert i_rst in the 2nd SHIFT cycle of i_k=5 -> next cycle state IDLE, o_Y=0, o_valid=0, o_ready=1, no result emitted.
REQ-037 Exhaustive check at WIDTH=4: all i_A and all i_k -> o_Y equals a rotate-right model by (4-k) mod 4.

Source files
------------

// File: rtl/bs_rotate_left_iter.sv
// Iterative rotate-left: one bit position per clock, with a valid/ready request
// port and a valid/ready result port whose result holds until it is taken.
module bs_rotate_left_iter #(
  parameter int WIDTH = 8,
  parameter int KW    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [KW-1:0]    i_k,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_Y,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [KW-1:0] CNT_ONE = KW'(1);

  state_t           state_r;
  logic [WIDTH-1:0] work_r;
  logic [KW-1:0]    cnt_r;
  logic [WIDTH-1:0] work_rot_s;

  assign work_rot_s = {work_r[WIDTH-2:0], work_r[WIDTH-1]};
  assign o_ready    = (state_r == IDLE);

  // Control FSM, datapath and registered outputs, reset wins over everything
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
      work_r  <= '0;
      cnt_r   <= '0;
      o_Y     <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_valid) begin
            work_r <= i_A;
            cnt_r  <= i_k;
            o_busy <= 1'b1;
            if (i_k != '0) begin
              state_r <= SHIFT;
            end else begin
              // zero rotate skips SHIFT and publishes the operand as-is
              state_r <= DONE;
              o_Y     <= i_A;
              o_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work_r <= work_rot_s;
          cnt_r  <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= DONE;
            o_Y     <= work_rot_s;
            o_valid <= 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            state_r <= IDLE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bs_rotate_left_iter.sv
// Self-checking bench for bs_rotate_left_iter: WIDTH=8 vectors and corner
// sequences, exhaustive WIDTH=4 sweep, and an illegal amount at WIDTH=6.
module tb_bs_rotate_left_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       v8, rd8, ov8, r8, busy8;
  logic [7:0] a8, y8;
  logic [2:0] k8;
  logic       v4, rd4, ov4, r4, busy4;
  logic [3:0] a4, y4;
  logic [1:0] k4;
  logic       v6, rd6, ov6, r6, busy6;
  logic [5:0] a6, y6;
  logic [2:0] k6;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb8[$];
  logic [3:0] sb4[$];

  typedef struct {
    logic [7:0] a;
    logic [2:0] k;
    logic [7:0] y;
  } vec_t;

  bs_rotate_left_iter #(.WIDTH(8), .KW(3)) u8 (
    .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rd8), .i_A(a8), .i_k(k8),
    .o_valid(ov8), .i_ready(r8), .o_Y(y8), .o_busy(busy8));
  bs_rotate_left_iter #(.WIDTH(4), .KW(2)) u4 (
    .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(rd4), .i_A(a4), .i_k(k4),
    .o_valid(ov4), .i_ready(r4), .o_Y(y4), .o_busy(busy4));
  bs_rotate_left_iter #(.WIDTH(6), .KW(3)) u6 (
    .i_clk(clk), .i_rst(rst), .i_valid(v6), .o_ready(rd6), .i_A(a6), .i_k(k6),
    .o_valid(ov6), .i_ready(r6), .o_Y(y6), .o_busy(busy6));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotr8(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} >> n;
    return d[7:0];
  endfunction

  function automatic logic [3:0] rotr4(input logic [3:0] a, input int n);
    logic [7:0] d;
    d = {a, a} >> n;
    return d[3:0];
  endfunction

  // called on the negedge right after the accept edge; returns edges counted
  task automatic wait_valid8(output int edges);
    edges = 1;
    while (ov8 !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [2:0] k, input logic [7:0] exp_y,
                      input string name);
    int edges;
    logic [7:0] exp;
    chk({name, "_ready"}, 32'(rd8), 32'd1);
    v8 = 1'b1; a8 = a; k8 = k;
    sb8.push_back(exp_y);
    @(negedge clk);
    v8 = 1'b0;
    if (k != 3'd0) chk({name, "_busy"}, 32'(busy8), 32'd1);
    else chk({name, "_busy"}, 32'(busy8), 32'd1);
    wait_valid8(edges);
    chk({name, "_lat"}, 32'(edges), 32'(k) + 32'd1);
    exp = sb8.pop_front();
    chk({name, "_y"}, 32'(y8), 32'(exp));
    @(negedge clk);
    chk({name, "_vclr"}, 32'(ov8), 32'd0);
    chk({name, "_idle"}, 32'(rd8), 32'd1);
  endtask

  initial begin
    vec_t vt[10];
    int edges, hits;
    logic [7:0] exp;
    logic [3:0] exp4;

    vt[0] = '{8'hB4, 3'd3, 8'hA5};
    vt[1] = '{8'h3C, 3'd0, 8'h3C};
    vt[2] = '{8'h01, 3'd7, 8'h80};
    vt[3] = '{8'h80, 3'd1, 8'h01};
    vt[4] = '{8'h0F, 3'd4, 8'hF0};
    vt[5] = '{8'h81, 3'd1, 8'h03};
    vt[6] = '{8'hA5, 3'd2, 8'h96};
    vt[7] = '{8'hFF, 3'd5, 8'hFF};
    vt[8] = '{8'h12, 3'd6, 8'h84};
    vt[9] = '{8'h6D, 3'd4, 8'hD6};

    rst = 1'b1;
    v8 = 1'b0; a8 = 8'h00; k8 = 3'd0; r8 = 1'b1;
    v4 = 1'b0; a4 = 4'h0;  k4 = 2'd0; r4 = 1'b1;
    v6 = 1'b0; a6 = 6'h00; k6 = 3'd0; r6 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rd8), 32'd1);
    chk("rst_valid", 32'(ov8), 32'd0);
    chk("rst_y", 32'(y8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run8(vt[i].a, vt[i].k, vt[i].y, $sformatf("vec%0d", i));

    // second request held during SHIFT must wait until IDLE
    v8 = 1'b1; a8 = 8'h01; k8 = 3'd7;
    sb8.push_back(8'h80);
    @(negedge clk);
    a8 = 8'h55; k8 = 3'd1;
    sb8.push_back(rotr8(8'h55, 7));
    chk("b2b_not_ready", 32'(rd8), 32'd0);
    wait_valid8(edges);
    chk("b2b_lat", 32'(edges), 32'd8);
    exp = sb8.pop_front();
    chk("b2b_y1", 32'(y8), 32'(exp));
    @(negedge clk);
    chk("b2b_idle", 32'(rd8), 32'd1);
    @(negedge clk);
    v8 = 1'b0;
    wait_valid8(edges);
    chk("b2b_lat2", 32'(edges), 32'd2);
    exp = sb8.pop_front();
    chk("b2b_y2", 32'(y8), 32'(exp));
    @(negedge clk);

    // backpressure: result holds for five cycles, then one handshake
    r8 = 1'b0;
    v8 = 1'b1; a8 = 8'hC3; k8 = 3'd2;
    sb8.push_back(rotr8(8'hC3, 6));
    @(negedge clk);
    v8 = 1'b0;
    wait_valid8(edges);
    exp = sb8.pop_front();
    chk("bp_y", 32'(y8), 32'(exp));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_v", 32'(ov8), 32'd1);
      chk("bp_hold_y", 32'(y8), 32'(exp));
    end
    chk("bp_ignored_req", 32'(rd8), 32'd0);
    r8 = 1'b1;
    @(negedge clk);
    chk("bp_vclr", 32'(ov8), 32'd0);
    chk("bp_idle", 32'(rd8), 32'd1);
    chk("bp_retain_y", 32'(y8), 32'(exp));

    // reset in the second SHIFT cycle aborts the operation
    v8 = 1'b1; a8 = 8'hB4; k8 = 3'd5;
    sb8.push_back(rotr8(8'hB4, 3));
    @(negedge clk);
    v8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb8.delete();
    chk("abort_ready", 32'(rd8), 32'd1);
    chk("abort_valid", 32'(ov8), 32'd0);
    chk("abort_y", 32'(y8), 32'd0);
    chk("abort_busy", 32'(busy8), 32'd0);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov8 === 1'b1) hits++;
    end
    chk("abort_no_result", 32'(hits), 32'd0);

    // reset beats an accept on the same edge
    v8 = 1'b1; a8 = 8'hFF; k8 = 3'd2; rst = 1'b1;
    @(negedge clk);
    v8 = 1'b0; rst = 1'b0;
    chk("rstprio_ready", 32'(rd8), 32'd1);
    chk("rstprio_busy", 32'(busy8), 32'd0);
    @(negedge clk);

    // exhaustive sweep at WIDTH=4 against a rotate-right model
    for (int a = 0; a < 16; a++) begin
      for (int k = 0; k < 4; k++) begin
        v4 = 1'b1; a4 = 4'(a); k4 = 2'(k);
        sb4.push_back(rotr4(4'(a), (4 - k) % 4));
        @(negedge clk);
        v4 = 1'b0;
        edges = 1;
        while (ov4 !== 1'b1 && edges < 20) begin
          @(negedge clk);
          edges++;
        end
        chk($sformatf("w4_lat_a%0d_k%0d", a, k), 32'(edges), 32'(k + 1));
        exp4 = sb4.pop_front();
        chk($sformatf("w4_y_a%0d_k%0d", a, k), 32'(y4), 32'(exp4));
        @(negedge clk);
      end
    end

    // illegal amount at WIDTH=6 still completes and returns to IDLE
    v6 = 1'b1; a6 = 6'h2D; k6 = 3'd7;
    @(negedge clk);
    v6 = 1'b0;
    edges = 1;
    while (ov6 !== 1'b1 && edges < 30) begin
      @(negedge clk);
      edges++;
    end
    chk("w6_illegal_done", 32'(ov6), 32'd1);
    @(negedge clk);
    chk("w6_illegal_idle", 32'(rd6), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
